// File: rtl/id_ex_status_stage.sv
// ID/EX pipeline register with architectural NZCV flags and a saturating condition-fail counter.
// Latency: ID->EX 1 cycle, flag commit visible 1 cycle after EX; qualified outputs combinational.
// Backpressure: freeze holds every register; flush or a taken branch injects a bubble even under freeze.
module id_ex_status_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [3:0]        id_cond,
  input  logic [3:0]        id_exe_cmd,
  input  logic              id_s,
  input  logic              id_b,
  input  logic              id_mem_r,
  input  logic              id_mem_w,
  input  logic              id_wb_en,
  input  logic              id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_val_rn,
  input  logic [DATA_W-1:0] id_val_rm,
  input  logic [11:0]       id_shift_operand,
  input  logic [23:0]       id_signed_imm24,
  input  logic [3:0]        id_dest,
  input  logic              cond_pass,
  input  logic [3:0]        alu_nzcv,
  output logic              ex_valid,
  output logic [3:0]        ex_cond,
  output logic [3:0]        ex_exe_cmd,
  output logic [3:0]        ex_dest,
  output logic              ex_imm,
  output logic              ex_s,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic [11:0]       ex_shift_operand,
  output logic [23:0]       ex_signed_imm24,
  output logic              ex_wb_en,
  output logic              ex_mem_r,
  output logic              ex_mem_w,
  output logic              ex_branch_taken,
  output logic              sr_n,
  output logic              sr_z,
  output logic              sr_c,
  output logic              sr_v,
  output logic [CNT_W-1:0]  cond_fail_cnt
);

  logic ex_b;
  logic reg_wb_en;
  logic reg_mem_r;
  logic reg_mem_w;
  logic live;
  logic bubble;
  logic flag_commit;
  logic fail_count;

  assign live            = ex_valid & cond_pass;
  assign ex_branch_taken = live & ex_b;
  assign ex_wb_en        = live & reg_wb_en;
  assign ex_mem_r        = live & reg_mem_r;
  assign ex_mem_w        = live & reg_mem_w;

  // A taken branch kills the instruction behind it regardless of freeze.
  assign bubble      = flush | ex_branch_taken;
  assign flag_commit = live & ex_s & ~freeze;
  assign fail_count  = ex_valid & ~cond_pass & ~freeze & ~(&cond_fail_cnt);

  // Data fields carry no side effects, so they load on a bubble too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_cond          <= '0;
      ex_exe_cmd       <= '0;
      ex_dest          <= '0;
      ex_imm           <= 1'b0;
      ex_pc            <= '0;
      ex_val_rn        <= '0;
      ex_val_rm        <= '0;
      ex_shift_operand <= '0;
      ex_signed_imm24  <= '0;
    end else if (bubble || !freeze) begin
      ex_cond          <= id_cond;
      ex_exe_cmd       <= id_exe_cmd;
      ex_dest          <= id_dest;
      ex_imm           <= id_imm;
      ex_pc            <= id_pc;
      ex_val_rn        <= id_val_rn;
      ex_val_rm        <= id_val_rm;
      ex_shift_operand <= id_shift_operand;
      ex_signed_imm24  <= id_signed_imm24;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_s      <= 1'b0;
      ex_b      <= 1'b0;
      reg_wb_en <= 1'b0;
      reg_mem_r <= 1'b0;
      reg_mem_w <= 1'b0;
    end else if (bubble) begin
      ex_valid  <= 1'b0;
      ex_s      <= 1'b0;
      ex_b      <= 1'b0;
      reg_wb_en <= 1'b0;
      reg_mem_r <= 1'b0;
      reg_mem_w <= 1'b0;
    end else if (!freeze) begin
      ex_valid  <= id_valid;
      ex_s      <= id_s;
      ex_b      <= id_b;
      reg_wb_en <= id_wb_en;
      reg_mem_r <= id_mem_r;
      reg_mem_w <= id_mem_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {sr_n, sr_z, sr_c, sr_v} <= 4'b0000;
    end else if (flag_commit) begin
      {sr_n, sr_z, sr_c, sr_v} <= alu_nzcv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_fail_cnt <= '0;
    end else if (fail_count) begin
      cond_fail_cnt <= cond_fail_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_id_ex_status_stage.sv
// Randomized bench for id_ex_status_stage against an instruction-level reference model.
module tb_id_ex_status_stage;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cond, cmd, dest;
    logic        imm, s, b, mr, mw, wb;
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic [23:0] off;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic freeze, flush, cond_pass;
  logic [3:0] alu_nzcv;
  instr_t id;

  logic ex_valid, ex_imm, ex_s, ex_wb_en, ex_mem_r, ex_mem_w, ex_branch_taken;
  logic [3:0] ex_cond, ex_exe_cmd, ex_dest;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [11:0] ex_shift_operand;
  logic [23:0] ex_signed_imm24;
  logic sr_n, sr_z, sr_c, sr_v;
  logic [CNT_W-1:0] cond_fail_cnt;

  // Reference model: the instruction sitting in EX, the flags, and the failure tally.
  instr_t m;
  logic [3:0] flags;
  int fails;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_status_stage #(.DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .id_valid(id.valid), .id_cond(id.cond), .id_exe_cmd(id.cmd),
    .id_s(id.s), .id_b(id.b), .id_mem_r(id.mr), .id_mem_w(id.mw), .id_wb_en(id.wb),
    .id_imm(id.imm), .id_pc(id.pc), .id_val_rn(id.rn), .id_val_rm(id.rm),
    .id_shift_operand(id.sh), .id_signed_imm24(id.off), .id_dest(id.dest),
    .cond_pass(cond_pass), .alu_nzcv(alu_nzcv),
    .ex_valid(ex_valid), .ex_cond(ex_cond), .ex_exe_cmd(ex_exe_cmd), .ex_dest(ex_dest),
    .ex_imm(ex_imm), .ex_s(ex_s), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm),
    .ex_shift_operand(ex_shift_operand), .ex_signed_imm24(ex_signed_imm24),
    .ex_wb_en(ex_wb_en), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
    .ex_branch_taken(ex_branch_taken),
    .sr_n(sr_n), .sr_z(sr_z), .sr_c(sr_c), .sr_v(sr_v), .cond_fail_cnt(cond_fail_cnt)
  );

  function automatic logic [255:0] expected();
    logic [255:0] v;
    logic q;
    q = m.valid & cond_pass;
    v = '0;
    v[158:0] = {m.valid, m.cond, m.cmd, m.dest, m.imm, m.s, m.pc, m.rn, m.rm, m.sh, m.off,
                m.wb & q, m.mr & q, m.mw & q, m.b & q, flags, 4'(fails)};
    return v;
  endfunction

  function automatic logic [255:0] observed();
    logic [255:0] v;
    v = '0;
    v[158:0] = {ex_valid, ex_cond, ex_exe_cmd, ex_dest, ex_imm, ex_s, ex_pc, ex_val_rn, ex_val_rm,
                ex_shift_operand, ex_signed_imm24, ex_wb_en, ex_mem_r, ex_mem_w, ex_branch_taken,
                sr_n, sr_z, sr_c, sr_v, cond_fail_cnt};
    return v;
  endfunction

  task automatic rand_id(input int b_pct);
    id.valid = 1'($urandom_range(0, 3) != 0);
    id.cond  = 4'($urandom);
    id.cmd   = 4'($urandom);
    id.dest  = 4'($urandom);
    id.imm   = 1'($urandom);
    id.s     = 1'($urandom);
    id.b     = 1'($urandom_range(0, 99) < b_pct);
    id.mr    = 1'($urandom);
    id.mw    = 1'($urandom);
    id.wb    = 1'($urandom);
    id.pc    = $urandom;
    id.rn    = $urandom;
    id.rm    = $urandom;
    id.sh    = 12'($urandom);
    id.off   = 24'($urandom);
  endtask

  // Advance the model by one clock using the inputs presented before the edge.
  task automatic step();
    instr_t nm;
    logic [3:0] nf;
    int nc;
    logic taken;
    taken = m.valid & m.b & cond_pass;
    nf = flags;
    nc = fails;
    if (!freeze && m.valid && cond_pass && m.s) nf = alu_nzcv;
    if (!freeze && m.valid && !cond_pass && nc < CNT_MAX) nc++;
    nm = m;
    if (flush || taken) begin
      nm = id;
      nm.valid = 1'b0; nm.s = 1'b0; nm.b = 1'b0; nm.mr = 1'b0; nm.mw = 1'b0; nm.wb = 1'b0;
    end else if (!freeze) begin
      nm = id;
    end
    @(posedge clk);
    #1;
    m = nm; flags = nf; fails = nc;
  endtask

  task automatic clear_ex();
    freeze = 1'b0; flush = 1'b1; cond_pass = 1'b1; rand_id(0);
    #1; step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      rand_id(20); freeze = 1'($urandom); flush = 1'b0; cond_pass = 1'($urandom);
      alu_nzcv = 4'($urandom);
      #1; step();
    end
    rand_id(20); cond_pass = 1'b1; flush = 1'b0; freeze = 1'b0;
    #2; rst_n = 1'b0; #1;
    m = '0; flags = 4'b0000; fails = 0;
    tests++;
    if (observed() !== 256'd0) begin
      errors++; $display("FAIL reset_async: got %h expected 0", observed());
    end
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    id.valid = 1'b1; id.b = 1'b0; #1;
    tests++;
    if ({sr_n, sr_z, sr_c, sr_v} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {sr_n, sr_z, sr_c, sr_v});
    end
    step();
    tests++;
    if (observed() !== expected() || ex_valid !== 1'b1) begin
      errors++; $display("FAIL reset_first_capture: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_advance();
    clear_ex();
    rand_id(0);
    id.valid = 1'b1; id.pc = 32'h40; id.dest = 4'd5; id.wb = 1'b1;
    #1; step();
    cond_pass = 1'b1; #1;
    tests++;
    if (ex_pc !== 32'h40 || ex_dest !== 4'd5 || ex_wb_en !== 1'b1 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL advance: got pc=%h dest=%0d wb=%b valid=%b expected pc=40 dest=5 wb=1 valid=1",
               ex_pc, ex_dest, ex_wb_en, ex_valid);
    end
  endtask

  task automatic test_flags();
    logic [CNT_W-1:0] cnt_before;
    clear_ex();
    rand_id(0); id.valid = 1'b1; id.s = 1'b1;
    #1; step();
    rand_id(0); id.valid = 1'b1; id.s = 1'b1; cond_pass = 1'b1; alu_nzcv = 4'b0100;
    #1; step();
    tests++;
    if ({sr_n, sr_z, sr_c, sr_v} !== 4'b0100 || observed() !== expected()) begin
      errors++; $display("FAIL flag_commit: got nzcv=%b expected 0100", {sr_n, sr_z, sr_c, sr_v});
    end
    cnt_before = cond_fail_cnt;
    rand_id(0); cond_pass = 1'b0; alu_nzcv = 4'b1011;
    #1;
    tests++;
    if ({ex_wb_en, ex_mem_r, ex_mem_w, ex_branch_taken} !== 4'b0000) begin
      errors++; $display("FAIL fail_squash: got %b expected 0000",
                         {ex_wb_en, ex_mem_r, ex_mem_w, ex_branch_taken});
    end
    step();
    tests++;
    if ({sr_n, sr_z, sr_c, sr_v} !== 4'b0100 ||
        int'(cond_fail_cnt) != ((int'(cnt_before) + 1 > CNT_MAX) ? CNT_MAX : int'(cnt_before) + 1)) begin
      errors++; $display("FAIL flag_no_commit: got nzcv=%b cnt=%0d expected nzcv=0100 cnt=%0d+1",
                         {sr_n, sr_z, sr_c, sr_v}, cond_fail_cnt, cnt_before);
    end
  endtask

  task automatic test_freeze();
    logic [255:0] held;
    clear_ex();
    rand_id(0); id.valid = 1'b1; id.s = 1'b1;
    #1; step();
    cond_pass = 1'b1; #1;
    held = expected();
    for (int i = 0; i < 3; i++) begin
      freeze = 1'b1; rand_id(50); alu_nzcv = 4'($urandom);
      #1; step();
      tests++;
      if (observed() !== held || observed() !== expected()) begin
        errors++; $display("FAIL freeze_hold[%0d]: got %h expected %h", i, observed(), held);
      end
    end
    freeze = 1'b0;
  endtask

  task automatic test_branch();
    for (int f = 0; f < 2; f++) begin
      clear_ex();
      rand_id(0); id.valid = 1'b1; id.b = 1'b1;
      #1; step();
      rand_id(0); id.valid = 1'b1; cond_pass = 1'b1; freeze = 1'(f);
      #1;
      tests++;
      if (ex_branch_taken !== 1'b1) begin
        errors++; $display("FAIL branch_taken[%0d]: got %b expected 1", f, ex_branch_taken);
      end
      step();
      tests++;
      if (ex_valid !== 1'b0 || observed() !== expected()) begin
        errors++; $display("FAIL branch_kill[%0d]: got valid=%b expected 0", f, ex_valid);
      end
      freeze = 1'b0;
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 21; i++) begin
      rand_id(0); id.valid = 1'b1;
      if (i % 3 == 0) id.cond = 4'b1111;
      cond_pass = 1'b0; freeze = 1'b0; flush = 1'b0;
      #1; step();
      tests++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL saturation_step[%0d]: got %h expected %h", i, observed(), expected());
      end
    end
    tests++;
    if (cond_fail_cnt !== 4'd15) begin
      errors++; $display("FAIL saturation_final: got %0d expected 15", cond_fail_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_id(25);
      freeze    = 1'($urandom_range(0, 3) == 0);
      flush     = 1'($urandom_range(0, 9) == 0);
      cond_pass = 1'($urandom);
      alu_nzcv  = 4'($urandom);
      #1;
      tests++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL random[%0d]: got %h expected %h", i, observed(), expected());
      end
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; cond_pass = 1'b0; alu_nzcv = 4'b0000;
    rand_id(0);
    m = '0; flags = 4'b0000; fails = 0;
    #12 rst_n = 1'b1;
    #4;
    test_reset();
    test_advance();
    test_flags();
    test_freeze();
    test_branch();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_status_stage.md
# id_ex_status_stage

ID/EX pipeline register plus architectural NZCV status register for the ARM core. Captures decoded fields from ID, presents them to EX, and drives the Z/C/N/V inputs of the downstream condition-check logic. It consumes that logic's pass/fail result (`cond_pass`) to qualify side effects, squash failed instructions, and commit ALU flags.

## Interface
- `DATA_W`, 32, width of PC and operand values
- `CNT_W`, 16, width of the saturating condition-fail counter

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `freeze`  in  1  hazard stall; hold all ID/EX contents
- `flush`  in  1  external bubble insert
- `id_valid`  in  1  ID slot holds a real instruction
- `id_cond`  in  4  condition field
- `id_exe_cmd`  in  4  ALU command
- `id_s`, `id_b`, `id_mem_r`, `id_mem_w`, `id_wb_en`  in  1 each  control bits
- `id_imm`  in  1  immediate operand select
- `id_pc`, `id_val_rn`, `id_val_rm`  in  DATA_W  PC and register values
- `id_shift_operand`  in  12  shifter operand
- `id_signed_imm24`  in  24  branch offset
- `id_dest`  in  4  destination register
- `cond_pass`  in  1  condition-check result for `ex_cond` against `sr_n/z/c/v`
- `alu_nzcv`  in  4  ALU flags {N,Z,C,V} for the EX instruction
- `ex_valid`  out  1  registered valid
- `ex_cond`, `ex_exe_cmd`, `ex_dest`  out  4  registered fields
- `ex_imm`, `ex_s`  out  1  registered fields
- `ex_pc`, `ex_val_rn`, `ex_val_rm`  out  DATA_W  registered
- `ex_shift_operand`  out  12, `ex_signed_imm24`  out  24  registered
- `ex_wb_en`, `ex_mem_r`, `ex_mem_w`  out  1  qualified: registered bit & `ex_valid` & `cond_pass`
- `ex_branch_taken`  out  1  `ex_valid` & `ex_b` & `cond_pass`
- `sr_n`, `sr_z`, `sr_c`, `sr_v`  out  1  status register to condition check
- `cond_fail_cnt`  out  CNT_W  count of valid EX instructions squashed by condition

## Operation
- Advance: no freeze, no bubble → all ID fields load; `ex_valid` ← `id_valid`.
- Bubble cases: `flush` or `ex_branch_taken` → `ex_valid` ← 0 and all control bits (`s`, `b`, `mem_r`, `mem_w`, `wb_en`) ← 0. Data fields load anyway; they are don't-care.
- Priority: bubble > freeze > advance. A taken branch or flush during freeze still kills the ID→EX transfer.
- Freeze with no bubble → every ID/EX register holds.
- Status commit: when `ex_valid` & `ex_s` & `cond_pass` & ~`freeze`, {N,Z,C,V} ← `alu_nzcv`. Commit happens once, on the cycle the instruction leaves EX. Failed-condition instructions never write flags.
- Failed-condition instruction: `ex_valid` & ~`cond_pass` → all qualified outputs are 0; the instruction becomes a NOP.
- `cond_fail_cnt`: increments by 1 on each edge where `ex_valid` & ~`cond_pass` & ~`freeze`. Saturates at all-ones, with no wrap.
- Cond 4'b1111 (NOP) always fails downstream and is counted like any other failure.

## Timing
- Async reset: every `ex_*` register, `ex_valid`, NZCV and `cond_fail_cnt` clear to 0 immediately. Qualified outputs are therefore 0.
- ID→EX latency: 1 cycle.
- Flag commit is visible on `sr_*` 1 cycle after the producing instruction's EX cycle. The next instruction, which is in EX in that same cycle, sees the updated flags. No forwarding path exists.
- Qualified outputs and `ex_branch_taken` are combinational from registered state plus `cond_pass`. No extra latency.
- Reset deassertion mid-stream: first valid capture occurs on the first rising edge with `rst_n`=1.

## Test plan
- Reset: drive random inputs, pulse `rst_n`=0 mid-cycle → all outputs 0 asynchronously, and `sr_*`=0 after release.
- Advance: `id_valid`=1, `id_pc`=0x40, `id_dest`=5, `id_wb_en`=1, `cond_pass`=1 → next cycle `ex_pc`=0x40, `ex_dest`=5, `ex_wb_en`=1.
- Flag commit: EX holds `ex_s`=1, `alu_nzcv`=4'b0100, `cond_pass`=1 → `sr_z`=1 next cycle. Repeat with `cond_pass`=0 → `sr_*` unchanged, `cond_fail_cnt`+1.
- Freeze: hold `freeze`=1 for 3 cycles while changing ID inputs and `alu_nzcv` → `ex_*` and `sr_*` constant, counter constant.
- Branch kill: EX has `ex_b`=1, `cond_pass`=1 → `ex_branch_taken`=1, next cycle `ex_valid`=0. Also applies with `freeze`=1 asserted simultaneously.
- Saturation: CNT_W=4, 20 consecutive failing instructions → `cond_fail_cnt`=15 and stays at 15.
